// File: rtl/div_pkg.sv
// Shared types and sign helpers for the sequential restoring divider.
// Helpers work on a MAX_W-bit container; callers cast to their own width.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_ZERO = 2'd1,
    ERR_OVF  = 2'd2
  } err_e;

  localparam int MAX_W = 128;
  localparam int IDX_W = $clog2(MAX_W);

  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

  // w is the operand width inside the container; the sign bit is v[w-1]
  function automatic logic sign_of(input logic [MAX_W-1:0] v, input int w, input logic is_signed);
    return is_signed & v[IDX_W'(w - 1)];
  endfunction

  function automatic logic [MAX_W-1:0] mag(input logic [MAX_W-1:0] v, input int w, input logic is_signed);
    return cond_neg(v, sign_of(v, w, is_signed));
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step on a 2W-bit partial remainder.
// Upper W bits are always < divisor on entry, so the difference fits in W bits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0]   dsr_i,
  output logic [2*WIDTH-1:0] rem_o,
  output logic               q_o
);

  logic [WIDTH:0]   top;
  logic [WIDTH-1:0] diff;

  assign top   = rem_i[2*WIDTH-1:WIDTH-1];
  assign q_o   = (top >= {1'b0, dsr_i});
  assign diff  = top[WIDTH-1:0] - dsr_i;
  assign rem_o = {(q_o ? diff : top[WIDTH-1:0]), rem_i[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, 2W/W, signed or unsigned, 1 or 2 quotient bits per cycle.
// WIDTH must be even, >= 8 and <= 64.
//   state  | meaning
//   S_IDLE | waiting for start; results and flags held
//   S_ITER | resolving BITS_PER_CYCLE quotient bits per cycle
//   S_FIX  | sign correction, range check, result/flag update, done pulse
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_div,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int K     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(K) + 1;
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  err_e               err_q, err_d;
  logic               signed_q, signed_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;

  logic               dvd_neg, dsr_neg;
  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0]   dsr_mag;
  logic               rng_ovf;

  assign dvd_neg = sign_of(MAX_W'(dividend), 2*WIDTH, signed_div);
  assign dsr_neg = sign_of(MAX_W'(divisor), WIDTH, signed_div);
  assign dvd_mag = (2*WIDTH)'(mag(MAX_W'(dividend), 2*WIDTH, signed_div));
  assign dsr_mag = WIDTH'(mag(MAX_W'(divisor), WIDTH, signed_div));

  // Steps chained combinationally; quotient bits come out MSB first
  logic [2*WIDTH-1:0]        chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] qbits;

  assign chain[0] = rem_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (chain[g]),
      .dsr_i (dsr_q),
      .rem_o (chain[g+1]),
      .q_o   (qbits[BITS_PER_CYCLE-1-g])
    );
  end

  // Magnitude fits in W bits here; only the signed range can still overflow
  assign rng_ovf = signed_q & (qneg_q ? (quo_q > HALF) : quo_q[WIDTH-1]);

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    signed_d    = signed_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    dz_d        = dz_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          signed_d = signed_div;
          qneg_d   = dvd_neg ^ dsr_neg;
          rneg_d   = dvd_neg;
          rem_d    = dvd_mag;
          dsr_d    = dsr_mag;
          quo_d    = '0;
          cnt_d    = CNT_W'(K - 1);
          if (dsr_mag == '0) begin
            err_d   = ERR_ZERO;
            state_d = S_FIX;
          end else if (dvd_mag[2*WIDTH-1:WIDTH] >= dsr_mag) begin
            err_d   = ERR_OVF;
            state_d = S_FIX;
          end else begin
            err_d   = ERR_NONE;
            state_d = S_ITER;
          end
        end
      end

      S_ITER: begin
        rem_d = chain[BITS_PER_CYCLE];
        quo_d = {quo_q[WIDTH-BITS_PER_CYCLE-1:0], qbits};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        case (err_q)
          ERR_ZERO: begin
            dz_d  = 1'b1;
            ovf_d = 1'b0;
          end
          ERR_OVF: begin
            dz_d  = 1'b0;
            ovf_d = 1'b1;
          end
          default: begin
            dz_d = 1'b0;
            if (rng_ovf) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d       = 1'b0;
              quotient_d  = WIDTH'(cond_neg(MAX_W'(quo_q), qneg_q));
              remainder_d = WIDTH'(cond_neg(MAX_W'(rem_q[2*WIDTH-1:WIDTH]), rneg_q));
            end
          end
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      err_q       <= ERR_NONE;
      signed_q    <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      signed_q    <= signed_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = dz_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: accepted requests are modelled with plain
// wide signed arithmetic; a monitor pops and compares on every done pulse.
module tb_div_seq;

  localparam int W   = 8;
  localparam int BPC = 2;
  localparam int DW  = 2 * W;
  localparam int EW  = 2 * W + 2;
  localparam int K   = W / BPC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          signed_div = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy, done, div_zero, overflow;
  logic [W-1:0]  quotient, remainder;

  div_seq #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_zero   (div_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: truncating division of the sign- or zero-extended operands
  function automatic exp_t model(input logic sg, input logic [DW-1:0] dvd, input logic [W-1:0] dsr);
    logic signed [EW-1:0] a, b, q, r, mq, pmax, nmin, umax;
    exp_t e;
    a    = sg ? {{2{dvd[DW-1]}}, dvd} : {2'b00, dvd};
    b    = sg ? {{(W+2){dsr[W-1]}}, dsr} : {{(W+2){1'b0}}, dsr};
    umax = EW'(1) << W;
    pmax = (EW'(1) << (W - 1)) - EW'(1);
    nmin = -(EW'(1) << (W - 1));
    e.q = last_q; e.r = last_r; e.dz = 1'b0; e.ov = 1'b0; e.lat = K + 1; e.acc = 0;
    if (b == 0) begin
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      q  = a / b;
      r  = a % b;
      mq = (q < 0) ? -q : q;
      if (mq >= umax) begin
        e.ov  = 1'b1;
        e.lat = 1;
      end else if (sg && (q > pmax || q < nmin)) begin
        e.ov = 1'b1;
      end else begin
        e.q = q[W-1:0];
        e.r = r[W-1:0];
      end
    end
    return e;
  endfunction

  // Any cycle with start high while idle is an acceptance at the next edge
  always @(negedge clk) begin : tracker
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      last_q = '0;
      last_r = '0;
    end else if (start && !busy) begin
      e      = model(signed_div, dividend, divisor);
      e.acc  = cyc + 1;
      last_q = e.q;
      last_r = e.r;
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("overflow", 64'(overflow), 64'(e.ov));
        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
        chk("busy_at_done", 64'(busy), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: got busy=1 expected 0 within 200 cycles");
    end
  endtask

  task automatic scramble();
    dividend   = DW'({$urandom, $urandom});
    divisor    = W'($urandom);
    signed_div = 1'($urandom);
  endtask

  task automatic issue(input logic sg, input logic [DW-1:0] dvd, input logic [W-1:0] dsr);
    wait_idle();
    start      = 1'b1;
    signed_div = sg;
    dividend   = dvd;
    divisor    = dsr;
    tick();
    start = 1'b0;
    scramble();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_quotient"}, 64'(quotient), 64'(0));
    chk({tag, "_remainder"}, 64'(remainder), 64'(0));
    chk({tag, "_div_zero"}, 64'(div_zero), 64'(0));
    chk({tag, "_overflow"}, 64'(overflow), 64'(0));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [W-1:0]  rw;
    logic [DW-1:0] rd;
    logic [W-1:0]  rs;

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    issue(1'b0, DW'(100), W'(7));
    issue(1'b1, DW'(16'hFF83), W'(8'h04));
    issue(1'b1, DW'(16'h0007), W'(8'hFE));
    issue(1'b1, DW'(16'hFF80), W'(8'h01));
    issue(1'b1, DW'(16'h0080), W'(8'h01));
    issue(1'b0, DW'(16'h0100), W'(8'h01));
    issue(1'b0, DW'(16'h1234), W'(0));
    issue(1'b1, DW'(16'hFF83), W'(0));
    issue(1'b0, DW'(16'hFFFF), W'(8'hFF));
    issue(1'b1, DW'(16'h8000), W'(8'hFF));

    // start pulse while busy must be ignored
    issue(1'b0, DW'(200), W'(9));
    start = 1'b1;
    scramble();
    tick();
    start = 1'b0;

    // start held through completion: accepted again in the done cycle
    wait_idle();
    start      = 1'b1;
    signed_div = 1'b1;
    dividend   = DW'(16'hFF9C);
    divisor    = W'(8'h07);
    tick();
    dividend = DW'(16'h0045);
    divisor  = W'(8'h05);
    tick();
    wait_idle();
    tick();
    start = 1'b0;

    for (int n = 0; n < 300; n++) begin
      rw = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rs = '0;
        1:       rs = W'(1);
        2:       rs = '1;
        3:       rs = {1'b1, {(W-1){1'b0}}};
        default: rs = W'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       rd = DW'({$urandom, $urandom});
        1:       rd = {{W{rw[W-1]}}, rw};
        2:       rd = {{W{1'b0}}, rw};
        3:       rd = {1'b1, {(DW-1){1'b0}}};
        default: rd = {W'($urandom_range(0, 3)), rw};
      endcase
      issue(1'($urandom), rd, rs);
      repeat ($urandom_range(0, 2)) tick();
    end

    // asynchronous reset in the middle of an iteration
    issue(1'b0, DW'(1000), W'(10));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    issue(1'b0, DW'(1000), W'(10));

    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_pending", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Parametrised sequential restoring divider for the CPU execution unit. Generalised successor to the 32/32 divider.
- Takes a double-width dividend and a single-width divisor, x86 DIV/IDIV style, producing a quotient and remainder.
- Signed or unsigned division, 1 or 2 quotient bits per cycle.
- Explicit divide-by-zero and quotient-overflow flags so the microcode can raise #DE without writing results.

Parameters:
WIDTH, 32, divisor/quotient/remainder width; must be even, >= 8.
BITS_PER_CYCLE, 1, quotient bits resolved per ITER cycle; legal values 1 or 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
signed_div  in  1  1 = two's-complement IDIV, 0 = unsigned DIV
dividend  in  2*WIDTH  numerator
divisor  in  WIDTH  denominator
busy  out  1  operation in progress; start is ignored while high
done  out  1  single-cycle completion pulse
quotient  out  WIDTH  result quotient; held between operations
remainder  out  WIDTH  result remainder; held between operations
div_zero  out  1  divisor was zero; valid with done
overflow  out  1  quotient not representable in WIDTH bits; valid with done

Behaviour:
- Reset (async on rst_n low, any state):
  - state=IDLE.
  - busy, done, div_zero, overflow = 0.
  - quotient, remainder = 0.
  - Internal registers cleared.
  - A reset mid-operation abandons the division; no done is produced.
- States: IDLE, ITER, FIX.
- IDLE, start=1, accepted at edge t0:
  - Latch signed_div and operand signs.
  - Latch magnitudes: |dividend| (2W bits), |divisor| (W bits). Magnitudes apply only when signed_div=1.
  - Set busy=1.
  - divisor==0 -> state=FIX with err=zero.
  - else if |dividend|[2W-1:W] >= |divisor| -> state=FIX with err=ovf. The magnitude quotient is >= 2^W.
  - else -> state=ITER, step counter=0.
- ITER:
  - K = WIDTH/BITS_PER_CYCLE cycles.
  - Each cycle performs BITS_PER_CYCLE restoring steps: shift the 2W-bit partial remainder left, compare its upper W+1 bits with |divisor|, subtract if greater or equal, and shift the quotient bit in MSB first.
  - After K cycles, state=FIX.
- FIX (one cycle, edge t0+K+1 for the normal path, t0+1 for the error path):
  - Normal path:
    - Quotient sign = sign(dividend) XOR sign(divisor).
    - Remainder sign = sign(dividend).
    - Result truncates toward zero.
  - Signed range check: overflow if a positive quotient magnitude > 2^(W-1)-1, or a negative quotient magnitude > 2^(W-1).
  - No error: register signed-corrected quotient/remainder; div_zero=0, overflow=0.
  - Any error: quotient/remainder keep previous values; set the corresponding flag (div_zero has priority); the other flag = 0.
  - done=1 for exactly one cycle. busy=0 in the same cycle. state=IDLE.
- Latency:
  - Normal: done visible after edge t0+K+1, i.e. W+2 cycles from start for BITS_PER_CYCLE=1.
  - Error: done visible after edge t0+1.
- Back-to-back: start may be asserted in the done cycle and is accepted (state is IDLE).
- Flag persistence: flags persist until the next FIX.
- Unsigned dividend with MSB set: plain magnitude; no sign handling.
- Operand change after acceptance: changing dividend/divisor/signed_div after t0 has no effect.

Decomposition:
- Package div_pkg:
  - State enum (IDLE/ITER/FIX).
  - Error encoding.
  - Magnitude/negate helper functions, parameterised by width.
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder, |divisor|.
  - Outputs: next remainder, quotient bit.
  - Instantiated BITS_PER_CYCLE times in series inside div_seq.

Test Plan:
1. W=32, unsigned 100/7 -> after 34 cycles done=1, q=14, r=2, flags 0; busy high exactly 33 cycles.
2. W=8, signed dividend 0xFF83 (-125) / 0x04 -> q=0xE1 (-31), r=0xFF (-1); dividend 0x0007 / 0xFE (-2) -> q=0xFD, r=0x01.
3. W=8 boundaries:
   - signed 0xFF80 / 0x01 -> q=0x80, no overflow.
   - signed 0x0080 / 0x01 -> overflow=1, q/r unchanged.
   - unsigned 0x0100 / 0x01 -> overflow=1 after 2 cycles.
4. Any dividend / 0 -> done after 2 cycles, div_zero=1, overflow=0, q/r retain the previous result.
5. start held high across completion -> second operation accepted in the done cycle.
   - start pulses while busy are ignored (result matches the first operands).
   - Operand changes mid-ITER do not affect the result.
6. rst_n low mid-ITER -> all outputs 0 immediately (async), no done. After release, a fresh 1000/10 (W=32, BITS_PER_CYCLE=2) -> q=100, r=0 after 18 cycles.
